// File: rtl/alu_seq_driver.sv
`default_nettype none
// ===========================================================================
// alu_seq_driver : issues one command at a time to an external combinational
//                  ALU and holds its response. Optional accumulator via the
//                  ALU_SEQ_ACC_EN macro.
// Revision: 1.0
// ===========================================================================
module alu_seq_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_eff_a;
  logic       w_accept;
  logic       w_capture;
  logic       w_retire;

  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_capture = (r_state == DRIVE);
  assign w_retire  = (r_state == RESP) && rsp_ready;

`ifdef ALU_SEQ_ACC_EN
  logic [3:0] r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 4'd0;
    end else if (w_capture) begin
      r_acc <= alu_res[3:0];
    end
  end

  assign w_eff_a = cmd_acc ? r_acc : cmd_a;
`else
  logic w_unused_acc;
  assign w_unused_acc = cmd_acc;
  assign w_eff_a      = cmd_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next_state = DRIVE;
      end
      DRIVE:   w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // alu_* stay untouched outside acceptance so the ALU sees stable operands
  // through DRIVE and for the whole of RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_op    <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 6'd0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      if (w_accept) begin
        alu_a   <= w_eff_a;
        alu_b   <= cmd_b;
        alu_op  <= cmd_op;
        rsp_err <= (cmd_op == 3'b011) && (cmd_b == 4'd0);
      end
      if (w_capture) begin
        rsp_data  <= alu_res[5:0];
        rsp_carry <= alu_res[6];
        rsp_zero  <= alu_res[7];
        rsp_valid <= 1'b1;
      end
      if (w_retire) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_driver.sv
`default_nettype none
// ===========================================================================
// tb_alu_seq_driver : directed scoreboard bench for alu_seq_driver with a
//                     behavioural combinational ALU on the alu_* bus.
// Revision: 1.0
// ===========================================================================
module tb_alu_seq_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;
  logic [7:0] op_count;

  alu_seq_driver dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_acc   (cmd_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: add, sub, mul, div, and, or, shl, xor; carry = any bit above [5:0].
  logic [7:0] alu_t;
  always_comb begin
    alu_t = 8'd0;
    case (alu_op)
      3'd0: alu_t = {4'd0, alu_a} + {4'd0, alu_b};
      3'd1: alu_t = {4'd0, alu_a} - {4'd0, alu_b};
      3'd2: alu_t = {4'd0, alu_a} * {4'd0, alu_b};
      3'd3: alu_t = (alu_b == 4'd0) ? 8'd0 : {4'd0, alu_a / alu_b};
      3'd4: alu_t = {4'd0, alu_a & alu_b};
      3'd5: alu_t = {4'd0, alu_a | alu_b};
      3'd6: alu_t = {4'd0, alu_a} << alu_b[1:0];
      default: alu_t = {4'd0, alu_a ^ alu_b};
    endcase
  end
  assign alu_res = {(alu_t[5:0] == 6'd0), |alu_t[7:6], alu_t[5:0]};

  typedef struct packed {
    logic [5:0] d;
    logic       c;
    logic       z;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         n_pops = 0;
  logic [7:0] exp_count = 8'd0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: samples just after the falling edge; a valid&ready here means
  // the response retires on the next rising edge.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      exp_count = 8'd0;
    end else if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        n_pops++;
        chk("rsp_data",  {26'd0, rsp_data}, {26'd0, e.d});
        chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.c});
        chk("rsp_zero",  {31'd0, rsp_zero}, {31'd0, e.z});
        chk("rsp_err",   {31'd0, rsp_err}, {31'd0, e.e});
      end
      chk("op_count_at_hs", {24'd0, op_count}, {24'd0, exp_count});
      exp_count = exp_count + 8'd1;
    end
  end

  // Called at a falling edge; returns at the falling edge after rsp_valid rises.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic acc, input logic [5:0] ed, input logic ec,
                       input logic ez, input logic ee);
    int   n;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    e.d = ed; e.c = ec; e.z = ez; e.e = ee;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_a     = 4'($urandom);
    cmd_b     = 4'($urandom);
    cmd_acc   = 1'($urandom);
    chk("drive_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("drive_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("drive_alu_op", {29'd0, alu_op}, {29'd0, op});
    chk("drive_alu_b", {28'd0, alu_b}, {28'd0, b});
    @(negedge clk);
    chk("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    int         pops0;
    logic [3:0] xa;
    logic [3:0] xb;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    cmd_acc = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", {26'd0, rsp_data}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_alu_a", {28'd0, alu_a}, 32'd0);
    chk("reset_op_count", {24'd0, op_count}, 32'd0);
    rst = 1'b0;

    // Reset during DRIVE aborts without a response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd7; cmd_b = 4'd1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    chk("mid_in_drive", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_op_count", {24'd0, op_count}, 32'd0);
    chk("abort_alu_a", {28'd0, alu_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset accepts.
    issue(3'd0, 4'd5, 4'd3, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_op_count", {24'd0, op_count}, 32'd1);

    issue(3'd3, 4'd9, 4'd0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    issue(3'd3, 4'd9, 4'd2, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    issue(3'd1, 4'd3, 4'd5, 1'b0, 6'h3E, 1'b1, 1'b0, 1'b0);
    issue(3'd2, 4'd15, 4'd15, 1'b0, 6'h21, 1'b1, 1'b0, 1'b0);
    issue(3'd4, 4'hC, 4'hA, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0);
    issue(3'd5, 4'h5, 4'hA, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0);
    issue(3'd7, 4'h5, 4'h5, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure with a stray command offered during RESP.
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(3'd2, 4'd3, 4'd4, 1'b0, 6'h0C, 1'b0, 1'b0, 1'b0);
    cnt = int'(op_count);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i < 8);
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", {26'd0, rsp_data}, 32'h0C);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_alu_a", {28'd0, alu_a}, 32'd3);
      chk("bp_op_count", {24'd0, op_count}, cnt);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_count", {24'd0, op_count}, (cnt + 1) & 255);

    // Accumulator chain: 2+3 then acc+4.
    issue(3'd0, 4'd2, 4'd3, 1'b0, 6'h05, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_ACC_EN
    issue(3'd0, 4'd0, 4'd4, 1'b1, 6'h09, 1'b0, 1'b0, 1'b0);
`else
    issue(3'd0, 4'd0, 4'd4, 1'b1, 6'h04, 1'b0, 1'b0, 1'b0);
`endif

    // 256 back-to-back xors from a fresh count wrap op_count to zero.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrap_start_count", {24'd0, op_count}, 32'd0);
    pops0 = n_pops;
    for (int i = 0; i < 256; i++) begin
      xa = 4'(i);
      xb = 4'(i >> 4);
      issue(3'd7, xa, xb, 1'b0, {2'b00, xa ^ xb}, 1'b0, (xa == xb), 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("wrap_op_count", {24'd0, op_count}, 32'd0);
    chk("wrap_pulses", n_pops - pops0, 32'd256);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
